// File: rtl/risc16_memory_dp.sv
// risc16_memory_dp -- byte-addressed, big-endian main memory for RiSC-16 cores.
//
// Two ports share one byte array:
//   - instruction port: read-only, registered, one-cycle latency, no enable.
//   - data port: req/ack handshake, per-byte write enables, registered reads.
// After reset an optional sweep zeroes the array one word group per cycle, so
// no single-cycle bulk reset of the storage is needed.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   When defined, a data request whose address is not a multiple of BPW
//   neither writes nor updates d_rdata; it acks with d_err=1.
//   When undefined, d_err is constant 0 and unaligned accesses are legal.
//
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   rst      in   synchronous active-low reset
//   busy     out  high while the clear sweep runs
//   i_addr   in   instruction fetch byte address
//   i_data   out  fetched word (registered)
//   d_req    in   data access request
//   d_we     in   1 = write, 0 = read
//   d_be     in   byte enables, lane k = byte at d_addr+k
//   d_addr   in   data byte address
//   d_wdata  in   write data
//   d_rdata  out  read data (registered, held until next read ack)
//   d_ack    out  one-cycle completion pulse
//   d_err    out  misalign trap flag
module risc16_memory_dp #(
  parameter int WORD_LENGTH    = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int MEM_SIZE       = 2**ADDR_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     busy,
  input  logic [ADDR_WIDTH-1:0]    i_addr,
  output logic [WORD_LENGTH-1:0]   i_data,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [WORD_LENGTH/8-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]    d_addr,
  input  logic [WORD_LENGTH-1:0]   d_wdata,
  output logic [WORD_LENGTH-1:0]   d_rdata,
  output logic                     d_ack,
  output logic                     d_err
);

  localparam int BPW  = WORD_LENGTH / 8;
  localparam int MAW  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int NGRP = MEM_SIZE / BPW;
  localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [7:0]      mem [MEM_SIZE];

  logic [WORD_LENGTH-1:0] i_data_q, d_rdata_q;
  logic                   d_ack_q, d_err_q;

  // Addresses reduced to the array size; byte arithmetic wraps naturally
  // because MEM_SIZE is a power of two.
  logic [MAW-1:0]  i_addr_m, d_addr_m, clr_base;
  logic            misalign;

  assign i_addr_m = MAW'(i_addr);
  assign d_addr_m = MAW'(d_addr);
  assign clr_base = MAW'(cnt_q * BPW);

  // Upper address bits beyond the array are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr, d_addr};

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = (d_addr_m % MAW'(BPW)) != '0;
`else
  assign misalign = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        // Leave on the same edge that clears the final group.
        if (cnt_q == CW'(NGRP - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q == S_CLEAR);

  // ---------------------------------------------------------------------
  // Combinational word assembly, big-endian: lowest address is the MSB.
  // ---------------------------------------------------------------------
  logic [WORD_LENGTH-1:0] i_word, d_word;

  always_comb begin
    i_word = '0;
    d_word = '0;
    for (int k = 0; k < BPW; k++) begin
      i_word[WORD_LENGTH-1-8*k -: 8] = mem[i_addr_m + MAW'(k)];
      d_word[WORD_LENGTH-1-8*k -: 8] = mem[d_addr_m + MAW'(k)];
    end
  end

  // ---------------------------------------------------------------------
  // Storage. No reset: contents survive reset unless the sweep clears them.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == S_CLEAR) begin
        for (int k = 0; k < BPW; k++)
          mem[clr_base + MAW'(k)] <= 8'h00;
      end else if (d_req && d_we && !misalign) begin
        for (int k = 0; k < BPW; k++)
          if (d_be[k])
            mem[d_addr_m + MAW'(k)] <= d_wdata[WORD_LENGTH-1-8*k -: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registered outputs. i_word/d_word are sampled from pre-edge contents,
  // so a same-edge write is never visible on i_data (read-before-write).
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      i_data_q  <= '0;
      d_rdata_q <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;
      if (state_q == S_CLEAR) begin
        i_data_q <= '0;
      end else begin
        i_data_q <= i_word;
        if (d_req) begin
          d_ack_q <= 1'b1;
          if (misalign)
            d_err_q <= 1'b1;
          else if (!d_we)
            d_rdata_q <= d_word;
        end
      end
    end
  end

  assign i_data  = i_data_q;
  assign d_rdata = d_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_err   = d_err_q;

endmodule
